// File: rtl/fpu_wb_arbiter_pkg.sv
// Shared types for the FPU register-file write-back path: register payloads,
// write requests, FCSR layout and exception bit positions.
package fpu_wb_arbiter_pkg;

  localparam int FPE_V = 4;
  localparam int FPE_Z = 3;
  localparam int FPE_O = 2;
  localparam int FPE_U = 1;
  localparam int FPE_I = 0;

  typedef logic [4:0] regaddr_t;
  typedef logic [4:0] fpuExcept_t;

  typedef enum logic [1:0] {
    FMT_S = 2'd0,
    FMT_D = 2'd1,
    FMT_H = 2'd2,
    FMT_Q = 2'd3
  } fpuFmt_t;

  typedef struct packed {
    fpuFmt_t     fmt;
    logic [31:0] val;
  } fpuReg_t;

  typedef struct packed {
    logic     we;
    regaddr_t waddr;
    fpuReg_t  wdata;
  } fpuRegWriteReq_t;

  typedef struct packed {
    fpuExcept_t cause;
    fpuExcept_t enables;
    fpuExcept_t flags;
  } fcsrReg_t;

  // A result waiting for (or winning) the write port.
  typedef struct packed {
    regaddr_t   waddr;
    fpuReg_t    wdata;
    fpuExcept_t except;
  } fpuResult_t;

  function automatic logic fpe_trap(fpuExcept_t e, fpuExcept_t en);
    return |(e & en);
  endfunction

endpackage

// File: rtl/fpu_wb_arbiter_fcsr.sv
// Combinational FCSR update for one retiring result: cause always records the
// result's exceptions; flags only accumulate when no enabled exception traps.
module fpu_fcsr_update
  import fpu_wb_arbiter_pkg::*;
(
  input  fcsrReg_t   fcsr,
  input  fpuExcept_t e,
  output fcsrReg_t   fcsr_wdata,
  output logic       trap
);

  always_comb begin
    trap             = fpe_trap(e, fcsr.enables);
    fcsr_wdata       = fcsr;
    fcsr_wdata.cause = e;
    if (!trap) fcsr_wdata.flags = fcsr.flags | e;
  end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Merges fixed-latency FPU results (A) and div/sqrt results (B, one-entry hold)
// onto the register-file write port; A has priority, B starvation stalls A.
module fpu_wb_arbiter
  import fpu_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            a_valid,
  input  regaddr_t        a_waddr,
  input  fpuReg_t         a_wdata,
  input  fpuExcept_t      a_except,
  output logic            a_stall,
  input  logic            b_valid,
  output logic            b_ready,
  input  regaddr_t        b_waddr,
  input  fpuReg_t         b_wdata,
  input  fpuExcept_t      b_except,
  input  fcsrReg_t        fcsr,
  output fpuRegWriteReq_t wr,
  output logic            fcsr_we,
  output fcsrReg_t        fcsr_wdata,
  output logic            fpe_req
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_MAX);

  logic            hold_valid;
  fpuResult_t      hold;
  logic [CW-1:0]   wait_cnt;
  logic            b_accept;
  logic            sel_a;
  logic            sel_h;
  logic            sel_any;
  fpuResult_t      sel;
  fcsrReg_t        upd;
  logic            trap;

  assign b_ready  = !hold_valid && !flush;
  assign b_accept = b_valid && b_ready;
  assign a_stall  = hold_valid && (wait_cnt == WAIT_MAX);

  // A always wins; flush suppresses any selection in its cycle.
  assign sel_a   = a_valid && !flush;
  assign sel_h   = !a_valid && hold_valid && !flush;
  assign sel_any = sel_a || sel_h;

  always_comb begin
    sel = hold;
    if (sel_a) sel = '{waddr: a_waddr, wdata: a_wdata, except: a_except};
  end

  fpu_fcsr_update u_fcsr_update (
    .fcsr       (fcsr),
    .e          (sel.except),
    .fcsr_wdata (upd),
    .trap       (trap)
  );

  // b_ready implies the hold is empty, so accept and drain never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (b_accept) begin
      hold_valid <= 1'b1;
      hold       <= '{waddr: b_waddr, wdata: b_wdata, except: b_except};
    end else if (sel_h) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || !hold_valid || sel_h) begin
      wait_cnt <= '0;
    end else if (a_valid && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr         <= '0;
      fcsr_we    <= 1'b0;
      fcsr_wdata <= '0;
      fpe_req    <= 1'b0;
    end else begin
      wr.we   <= 1'b0;
      fcsr_we <= sel_any;
      fpe_req <= sel_any && trap;
      if (sel_any) begin
        wr.we      <= !trap;
        wr.waddr   <= sel.waddr;
        wr.wdata   <= sel.wdata;
        fcsr_wdata <= upd;
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Bench for fpu_wb_arbiter: table of single A retirements, hand sequences for
// B handshake, starvation, flush and reset, then random traffic vs a queue model.
module tb_fpu_wb_arbiter;
  import fpu_wb_arbiter_pkg::*;

  localparam int SM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            a_valid;
  regaddr_t        a_waddr;
  fpuReg_t         a_wdata;
  fpuExcept_t      a_except;
  logic            a_stall;
  logic            b_valid;
  logic            b_ready;
  regaddr_t        b_waddr;
  fpuReg_t         b_wdata;
  fpuExcept_t      b_except;
  fcsrReg_t        fcsr;
  fpuRegWriteReq_t wr;
  logic            fcsr_we;
  fcsrReg_t        fcsr_wdata;
  logic            fpe_req;

  // Register-file side of the FCSR, with write bypass onto the fcsr input.
  fcsrReg_t   fcsr_q = '0;
  logic       clr_flags;
  fpuExcept_t en_cfg;

  int checks = 0;
  int errors = 0;

  fpu_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .a_valid    (a_valid),
    .a_waddr    (a_waddr),
    .a_wdata    (a_wdata),
    .a_except   (a_except),
    .a_stall    (a_stall),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_waddr    (b_waddr),
    .b_wdata    (b_wdata),
    .b_except   (b_except),
    .fcsr       (fcsr),
    .wr         (wr),
    .fcsr_we    (fcsr_we),
    .fcsr_wdata (fcsr_wdata),
    .fpe_req    (fpe_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_flags) fcsr_q <= '0;
    else if (fcsr_we) fcsr_q <= fcsr_wdata;
  end

  always_comb begin
    fcsr         = fcsr_we ? fcsr_wdata : fcsr_q;
    fcsr.enables = en_cfg;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    regaddr_t   waddr;
    fpuReg_t    wdata;
    fpuExcept_t e;
    fpuExcept_t en;
    logic       exp_we;
    logic       exp_fpe;
    fpuExcept_t exp_flags;
  } vec_t;

  vec_t tbl[6];

  // Random-phase model state
  fpuResult_t held[$];
  int         lost;
  fpuExcept_t m_flags;

  initial begin
    int         n;
    fpuResult_t ra, rb, r;
    logic       ret, acc, tr, exp_stall, exp_bready;
    logic       e_we, e_fpe, e_fw;
    fcsrReg_t   e_fcsr;

    tbl[0] = '{5'd3,  '{FMT_S, 32'h3F800000}, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000};
    tbl[1] = '{5'd9,  '{FMT_S, 32'h7FC00000}, 5'b10000, 5'b10000, 1'b0, 1'b1, 5'b00000};
    tbl[2] = '{5'd12, '{FMT_D, 32'h12345678}, 5'b00011, 5'b00100, 1'b1, 1'b0, 5'b00011};
    tbl[3] = '{5'd31, '{FMT_H, 32'hDEADBEEF}, 5'b00100, 5'b00100, 1'b0, 1'b1, 5'b00000};
    tbl[4] = '{5'd0,  '{FMT_Q, 32'h00000001}, 5'b11111, 5'b00000, 1'b1, 1'b0, 5'b11111};
    tbl[5] = '{5'd17, '{FMT_S, 32'hC0490FDB}, 5'b01010, 5'b00001, 1'b1, 1'b0, 5'b01010};

    rst = 1'b1; flush = 1'b0; clr_flags = 1'b1; en_cfg = '0;
    a_valid = 1'b0; a_waddr = '0; a_wdata = '0; a_except = '0;
    b_valid = 1'b0; b_waddr = '0; b_wdata = '0; b_except = '0;
    tick(); tick();
    rst = 1'b0; clr_flags = 1'b0;
    #1;
    chk("rst_we", wr.we, 0);
    chk("rst_waddr", wr.waddr, 0);
    chk("rst_fcsr_we", fcsr_we, 0);
    chk("rst_fcsr_wdata", fcsr_wdata, 0);
    chk("rst_fpe", fpe_req, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_a_stall", a_stall, 0);

    // Single A retirements from a clean FCSR
    for (int i = 0; i < 6; i++) begin
      clr_flags = 1'b1; en_cfg = tbl[i].en;
      tick();
      clr_flags = 1'b0;
      a_valid = 1'b1; a_waddr = tbl[i].waddr; a_wdata = tbl[i].wdata; a_except = tbl[i].e;
      tick();
      a_valid = 1'b0;
      chk($sformatf("tbl%0d_we", i), wr.we, tbl[i].exp_we);
      chk($sformatf("tbl%0d_fpe", i), fpe_req, tbl[i].exp_fpe);
      chk($sformatf("tbl%0d_fcsr_we", i), fcsr_we, 1);
      chk($sformatf("tbl%0d_cause", i), fcsr_wdata.cause, tbl[i].e);
      chk($sformatf("tbl%0d_flags", i), fcsr_wdata.flags, tbl[i].exp_flags);
      chk($sformatf("tbl%0d_en", i), fcsr_wdata.enables, tbl[i].en);
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_waddr", i), wr.waddr, tbl[i].waddr);
        chk($sformatf("tbl%0d_wdata", i), wr.wdata, tbl[i].wdata);
      end
      tick();
      chk($sformatf("tbl%0d_fpe_pulse", i), fpe_req, 0);
      chk($sformatf("tbl%0d_idle", i), fcsr_we, 0);
    end

    // Back-to-back flag accumulation
    clr_flags = 1'b1; en_cfg = '0;
    tick();
    clr_flags = 1'b0;
    a_valid = 1'b1; a_waddr = 5'd4; a_except = 5'b00001;
    tick();
    chk("acc1_flags", fcsr_wdata.flags, 5'b00001);
    a_waddr = 5'd5; a_except = 5'b00100;
    tick();
    a_valid = 1'b0; a_except = '0;
    chk("acc2_flags", fcsr_wdata.flags, 5'b00101);
    chk("acc2_cause", fcsr_wdata.cause, 5'b00100);
    tick();

    // B while A idle: two-cycle handshake-to-write
    b_valid = 1'b1; b_waddr = 5'd7; b_wdata = '{FMT_D, 32'h40490FDB}; b_except = '0;
    #1;
    chk("b_ready_t", b_ready, 1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("b_ready_t1", b_ready, 0);
    chk("b_we_t1", wr.we, 0);
    tick();
    chk("b_we_t2", wr.we, 1);
    chk("b_waddr_t2", wr.waddr, 7);
    chk("b_wdata_t2", wr.wdata, {FMT_D, 32'h40490FDB});
    tick();

    // Starvation: hold B, keep A busy until a_stall
    b_valid = 1'b1; b_waddr = 5'd20; b_wdata = '{FMT_S, 32'hAAAA5555};
    tick();
    b_valid = 1'b0;
    n = 0;
    while (!a_stall && n < 10) begin
      a_valid = 1'b1; a_waddr = 5'd1; a_except = '0;
      tick();
      n++;
      chk("starve_a_waddr", wr.waddr, 1);
    end
    a_valid = 1'b0;
    chk("starve_lost", n, SM);
    chk("starve_stall", a_stall, 1);
    tick();
    chk("starve_b_we", wr.we, 1);
    chk("starve_b_waddr", wr.waddr, 20);
    chk("starve_stall_clr", a_stall, 0);
    chk("starve_b_ready", b_ready, 1);
    tick();

    // Flush drops the held result and suppresses A in that cycle
    b_valid = 1'b1; b_waddr = 5'd25; b_wdata = '{FMT_S, 32'h11111111};
    tick();
    b_valid = 1'b0; flush = 1'b1; a_valid = 1'b1; a_waddr = 5'd26;
    #1;
    chk("flush_b_ready", b_ready, 0);
    tick();
    flush = 1'b0; a_valid = 1'b0;
    #1;
    chk("flush_we", wr.we, 0);
    chk("flush_fcsr_we", fcsr_we, 0);
    chk("flush_b_ready_next", b_ready, 1);
    tick();
    chk("flush_no_b", wr.we, 0);

    // Reset discards a held result
    b_valid = 1'b1; b_waddr = 5'd11;
    tick();
    b_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_b_ready", b_ready, 1);
    chk("mrst_we", wr.we, 0);
    tick();
    chk("mrst_no_b", wr.we, 0);

    // Random traffic against a queue model
    clr_flags = 1'b1; en_cfg = '0;
    tick();
    clr_flags = 1'b0;
    held.delete(); lost = 0; m_flags = '0;
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) en_cfg = fpuExcept_t'($urandom & $urandom);
      exp_stall  = (held.size() != 0) && (lost == SM);
      exp_bready = (held.size() == 0) && !flush;
      a_valid  = !exp_stall && ($urandom_range(0, 99) < 55);
      a_waddr  = regaddr_t'($urandom_range(0, 31));
      a_wdata  = '{fpuFmt_t'($urandom_range(0, 3)), $urandom};
      a_except = fpuExcept_t'($urandom & $urandom);
      b_valid  = ($urandom_range(0, 1) == 1);
      b_waddr  = regaddr_t'($urandom_range(0, 31));
      b_wdata  = '{fpuFmt_t'($urandom_range(0, 3)), $urandom};
      b_except = fpuExcept_t'($urandom & $urandom);
      @(negedge clk);
      chk("rnd_b_ready", b_ready, exp_bready);
      chk("rnd_a_stall", a_stall, exp_stall);
      if (a_valid && !rst) chk("rnd_a_protocol", a_stall, 0);

      ra = '{waddr: a_waddr, wdata: a_wdata, except: a_except};
      rb = '{waddr: b_waddr, wdata: b_wdata, except: b_except};
      r = ra; ret = 1'b0;
      if (rst || flush) begin
        held.delete(); lost = 0;
      end else begin
        acc = b_valid && (held.size() == 0);
        if (a_valid) begin
          ret = 1'b1;
          if (held.size() != 0) lost = (lost + 1 > SM) ? SM : lost + 1;
        end else if (held.size() != 0) begin
          ret = 1'b1; r = held.pop_front(); lost = 0;
        end
        if (acc) held.push_back(rb);
      end
      tr     = |(r.except & en_cfg);
      e_fw   = ret;
      e_we   = ret && !tr;
      e_fpe  = ret && tr;
      e_fcsr = '{cause: r.except, enables: en_cfg, flags: tr ? m_flags : (m_flags | r.except)};
      if (ret) m_flags = e_fcsr.flags;

      tick();
      chk("rnd_we", wr.we, e_we);
      chk("rnd_fcsr_we", fcsr_we, e_fw);
      chk("rnd_fpe", fpe_req, e_fpe);
      if (e_fw) chk("rnd_fcsr_wdata", fcsr_wdata, e_fcsr);
      if (e_we) begin
        chk("rnd_waddr", wr.waddr, r.waddr);
        chk("rnd_wdata", wr.wdata, r.wdata);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
